hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RV32I pipeline. Drives the decode stage's `stall_signal`, `freeze_stall` and `flushing_inst`, plus IF/EX squash controls. It sequences three activities:
- memory-wait freezes, from tracking outstanding imem/dmem requests;
- taken-branch/jump flushes, including dropping a wrong-path fetch still in flight;
- RAW-hazard stalls.

It sits beside the pipeline registers. It observes the ID/EX/MEM/WB register-address fields and controls when each stage advances.

---
 rtl/rv32i_types.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_fwd_unit.sv | 41 ++++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: hazard FSM states, forward-select encoding,
// and the producer-match helper used by the hazard logic.
package rv32i_types;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;

  typedef enum logic [1:0] {
    fwd_rf  = 2'd0,
    fwd_mem = 2'd1,
    fwd_wb  = 2'd2
  } fwd_sel_t;

  // A stage produces a register only if valid, writing, and not targeting x0.
  function automatic logic prod_hit(input logic       valid,
                                    input logic       we,
                                    input logic [4:0] rd,
                                    input logic [4:0] src);
    return valid & we & (rd != 5'd0) & (rd == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage status in, stage controls out.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if;
   import rv32i_types::*;

   logic       id_valid;
   logic [4:0] id_rs1_s, id_rs2_s;
   logic       id_uses_rs1, id_uses_rs2;
   logic       ex_valid, ex_regf_we, ex_is_load;
   logic [4:0] ex_rd_s, ex_rs1_s, ex_rs2_s;
   logic       mem_valid, mem_regf_we;
   logic [4:0] mem_rd_s;
   logic       wb_valid, wb_regf_we;
   logic [4:0] wb_rd_s;
   logic       br_taken;
   logic       imem_req, imem_resp, dmem_req, dmem_resp;

   logic       freeze_stall, stall_signal, bubble_ex;
   logic       flushing_inst, flush_if, drop_imem_resp;
   fwd_sel_t   fwd_a_sel, fwd_b_sel;

   modport master (
      output id_valid, id_rs1_s, id_rs2_s, id_uses_rs1, id_uses_rs2,
             ex_valid, ex_regf_we, ex_is_load, ex_rd_s, ex_rs1_s, ex_rs2_s,
             mem_valid, mem_regf_we, mem_rd_s, wb_valid, wb_regf_we, wb_rd_s,
             br_taken, imem_req, imem_resp, dmem_req, dmem_resp,
      input  freeze_stall, stall_signal, bubble_ex, flushing_inst, flush_if,
             drop_imem_resp, fwd_a_sel, fwd_b_sel
   );

   modport slave (
      input  id_valid, id_rs1_s, id_rs2_s, id_uses_rs1, id_uses_rs2,
             ex_valid, ex_regf_we, ex_is_load, ex_rd_s, ex_rs1_s, ex_rs2_s,
             mem_valid, mem_regf_we, mem_rd_s, wb_valid, wb_regf_we, wb_rd_s,
             br_taken, imem_req, imem_resp, dmem_req, dmem_resp,
      output freeze_stall, stall_signal, bubble_ex, flushing_inst, flush_if,
             drop_imem_resp, fwd_a_sel, fwd_b_sel
   );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use detection and EX operand forward selection
// (MEM result preferred over WB value). Used only in the forwarding build.
module hazard_fwd_unit
   import rv32i_types::*;
(
   input  logic       id_valid,
   input  logic [4:0] id_rs1_s,
   input  logic [4:0] id_rs2_s,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_valid,
   input  logic       ex_regf_we,
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd_s,
   input  logic [4:0] ex_rs1_s,
   input  logic [4:0] ex_rs2_s,
   input  logic       mem_valid,
   input  logic       mem_regf_we,
   input  logic [4:0] mem_rd_s,
   input  logic       wb_valid,
   input  logic       wb_regf_we,
   input  logic [4:0] wb_rd_s,
   output logic       load_use,
   output fwd_sel_t   fwd_a_sel,
   output fwd_sel_t   fwd_b_sel
);

   function automatic fwd_sel_t pick(input logic [4:0] src);
      if (prod_hit(mem_valid, mem_regf_we, mem_rd_s, src)) return fwd_mem;
      if (prod_hit(wb_valid, wb_regf_we, wb_rd_s, src))    return fwd_wb;
      return fwd_rf;
   endfunction

   assign load_use = id_valid & ex_is_load &
                     ((id_uses_rs1 & prod_hit(ex_valid, ex_regf_we, ex_rd_s, id_rs1_s)) |
                      (id_uses_rs2 & prod_hit(ex_valid, ex_regf_we, ex_rd_s, id_rs2_s)));

   assign fwd_a_sel = pick(ex_rs1_s);
   assign fwd_b_sel = pick(ex_rs2_s);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: memory-wait freeze, redirect flush,
// wrong-path fetch drop and RAW stalls. Define HAZARD_FWD_EN for forwarding.
module hazard_ctrl
   import rv32i_types::*;
#(
   parameter int FLUSH_CYCLES = 2
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave hz
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   hz_state_t  state_q, state_d;
   logic       imem_pend_q, dmem_pend_q, wrong_path_q, wrong_path_d;
   logic [2:0] flush_cnt_q, flush_cnt_d;

   logic       raw_hazard, frozen;
   fwd_sel_t   fwd_a_c, fwd_b_c;

`ifdef HAZARD_FWD_EN
   hazard_fwd_unit u_fwd (
      .id_valid    (hz.id_valid),    .id_rs1_s    (hz.id_rs1_s),
      .id_rs2_s    (hz.id_rs2_s),    .id_uses_rs1 (hz.id_uses_rs1),
      .id_uses_rs2 (hz.id_uses_rs2), .ex_valid    (hz.ex_valid),
      .ex_regf_we  (hz.ex_regf_we),  .ex_is_load  (hz.ex_is_load),
      .ex_rd_s     (hz.ex_rd_s),     .ex_rs1_s    (hz.ex_rs1_s),
      .ex_rs2_s    (hz.ex_rs2_s),    .mem_valid   (hz.mem_valid),
      .mem_regf_we (hz.mem_regf_we), .mem_rd_s    (hz.mem_rd_s),
      .wb_valid    (hz.wb_valid),    .wb_regf_we  (hz.wb_regf_we),
      .wb_rd_s     (hz.wb_rd_s),     .load_use    (raw_hazard),
      .fwd_a_sel   (fwd_a_c),        .fwd_b_sel   (fwd_b_c)
   );
`else
   // Without write-through, the consumer waits until the producer leaves WB.
   function automatic logic any_prod(input logic [4:0] src);
      return prod_hit(hz.ex_valid,  hz.ex_regf_we,  hz.ex_rd_s,  src) |
             prod_hit(hz.mem_valid, hz.mem_regf_we, hz.mem_rd_s, src) |
             prod_hit(hz.wb_valid,  hz.wb_regf_we,  hz.wb_rd_s,  src);
   endfunction

   assign raw_hazard = hz.id_valid &
                       ((hz.id_uses_rs1 & any_prod(hz.id_rs1_s)) |
                        (hz.id_uses_rs2 & any_prod(hz.id_rs2_s)));
   assign fwd_a_c = fwd_rf;
   assign fwd_b_c = fwd_rf;

   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{hz.ex_rs1_s, hz.ex_rs2_s, hz.ex_is_load};
`endif

   assign frozen = (imem_pend_q & ~hz.imem_resp) | (dmem_pend_q & ~hz.dmem_resp);

   logic stall_c, flushing_c, flush_if_c, drop_c;
   fwd_sel_t fwd_a_o, fwd_b_o;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      wrong_path_d = wrong_path_q;
      stall_c      = 1'b0;
      flushing_c   = 1'b0;
      flush_if_c   = 1'b0;
      fwd_a_o      = fwd_rf;
      fwd_b_o      = fwd_rf;
      drop_c       = wrong_path_q & hz.imem_resp;

      if (drop_c) wrong_path_d = 1'b0;
      // A redirect seen while its fetch is still outstanding marks that fetch wrong-path.
      if (state_q == RUN && hz.br_taken && imem_pend_q && !hz.imem_resp)
         wrong_path_d = 1'b1;

      if (!frozen) begin
         fwd_a_o = fwd_a_c;
         fwd_b_o = fwd_b_c;
         unique case (state_q)
            RUN: begin
               if (hz.br_taken) begin
                  flushing_c = 1'b1;
                  flush_if_c = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d     = FLUSH;
                     flush_cnt_d = FLUSH_LOAD;
                  end
               end else if (raw_hazard) begin
                  stall_c = 1'b1;
               end
            end
            FLUSH: begin
               flush_if_c = 1'b1;
               if (hz.br_taken) begin
                  flushing_c  = 1'b1;
                  flush_cnt_d = FLUSH_LOAD;
               end else begin
                  flush_cnt_d = flush_cnt_q - 3'd1;
                  if (flush_cnt_q == 3'd1) state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         imem_pend_q  <= 1'b0;
         dmem_pend_q  <= 1'b0;
         wrong_path_q <= 1'b0;
         flush_cnt_q  <= 3'd0;
      end else begin
         state_q      <= state_d;
         imem_pend_q  <= hz.imem_req | (imem_pend_q & ~hz.imem_resp);
         dmem_pend_q  <= hz.dmem_req | (dmem_pend_q & ~hz.dmem_resp);
         wrong_path_q <= wrong_path_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign hz.freeze_stall   = ~rst & frozen;
   assign hz.stall_signal   = ~rst & stall_c;
   assign hz.bubble_ex      = ~rst & stall_c;
   assign hz.flushing_inst  = ~rst & flushing_c;
   assign hz.flush_if       = ~rst & flush_if_c;
   assign hz.drop_imem_resp = ~rst & drop_c;
   assign hz.fwd_a_sel      = rst ? fwd_rf : fwd_a_o;
   assign hz.fwd_b_sel      = rst ? fwd_rf : fwd_b_o;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (FLUSH_CYCLES=2); output vector is
// {freeze, stall, bubble, flushing_inst, flush_if, drop, fwd_a[1:0], fwd_b[1:0]}.
module tb_hazard_ctrl;
   import rv32i_types::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   hazard_ctrl_if hz ();

   hazard_ctrl #(.FLUSH_CYCLES(2)) dut (.clk(clk), .rst(rst), .hz(hz));

   always #5 clk = ~clk;

   function automatic logic [9:0] ev(input logic f, s, fi, fif, d,
                                     input logic [1:0] fa, fb);
      return {f, s, s, fi, fif, d, fa, fb};
   endfunction

   function automatic logic [9:0] outs();
      return {hz.freeze_stall, hz.stall_signal, hz.bubble_ex, hz.flushing_inst,
              hz.flush_if, hz.drop_imem_resp, 2'(hz.fwd_a_sel), 2'(hz.fwd_b_sel)};
   endfunction

   task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [9:0] exp);
      #1 check(tag, outs(), exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      hz.id_valid = 0; hz.id_rs1_s = 0; hz.id_rs2_s = 0;
      hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
      hz.ex_valid = 0; hz.ex_regf_we = 0; hz.ex_is_load = 0;
      hz.ex_rd_s = 0; hz.ex_rs1_s = 0; hz.ex_rs2_s = 0;
      hz.mem_valid = 0; hz.mem_regf_we = 0; hz.mem_rd_s = 0;
      hz.wb_valid = 0; hz.wb_regf_we = 0; hz.wb_rd_s = 0;
      hz.br_taken = 0; hz.imem_req = 0; hz.imem_resp = 0;
      hz.dmem_req = 0; hz.dmem_resp = 0;
   endtask

   // ID: add x6, x5, x1
   task automatic id_add();
      hz.id_valid = 1; hz.id_rs1_s = 5; hz.id_rs2_s = 1;
      hz.id_uses_rs1 = 1; hz.id_uses_rs2 = 1;
   endtask

   // EX: lw x5 (a load, so it stalls in both builds)
   task automatic ex_lw_x5();
      hz.ex_valid = 1; hz.ex_regf_we = 1; hz.ex_is_load = 1; hz.ex_rd_s = 5;
   endtask

   initial begin
      clr();
      rst = 1;
      id_add(); ex_lw_x5(); hz.br_taken = 1; hz.imem_resp = 1;
      chk("reset_outputs", 10'd0);
      tick(); tick();
      rst = 0; clr();
      chk("idle", 10'd0);

`ifndef HAZARD_FWD_EN
      id_add();
      hz.ex_valid = 1; hz.ex_regf_we = 1; hz.ex_rd_s = 5;
      chk("nofwd_ex_prod", ev(0, 1, 0, 0, 0, 0, 0));
      tick(); hz.ex_valid = 0;
      hz.mem_valid = 1; hz.mem_regf_we = 1; hz.mem_rd_s = 5; hz.ex_rs1_s = 5;
      chk("nofwd_mem_prod", ev(0, 1, 0, 0, 0, 0, 0));
      tick(); hz.mem_valid = 0;
      hz.wb_valid = 1; hz.wb_regf_we = 1; hz.wb_rd_s = 5;
      chk("nofwd_wb_prod", ev(0, 1, 0, 0, 0, 0, 0));
      tick(); hz.wb_valid = 0;
      chk("nofwd_released", 10'd0);
      hz.ex_valid = 1; hz.ex_regf_we = 0; hz.ex_rd_s = 5;
      chk("nofwd_no_we", 10'd0);
      hz.ex_regf_we = 1; hz.ex_rd_s = 0; hz.id_rs1_s = 0;
      chk("nofwd_x0", 10'd0);
      hz.ex_rd_s = 1; hz.id_uses_rs2 = 0;
      chk("nofwd_rs2_unused", 10'd0);
      hz.id_uses_rs2 = 1;
      chk("nofwd_rs2_used", ev(0, 1, 0, 0, 0, 0, 0));
`else
      id_add(); ex_lw_x5();
      chk("fwd_load_use", ev(0, 1, 0, 0, 0, 0, 0));
      hz.ex_is_load = 0;
      chk("fwd_alu_no_stall", 10'd0);
      clr(); hz.ex_rs1_s = 5;
      hz.mem_valid = 1; hz.mem_regf_we = 1; hz.mem_rd_s = 5;
      chk("fwd_a_mem", ev(0, 0, 0, 0, 0, 1, 0));
      hz.wb_valid = 1; hz.wb_regf_we = 1; hz.wb_rd_s = 5;
      chk("fwd_mem_wins", ev(0, 0, 0, 0, 0, 1, 0));
      hz.mem_valid = 0; hz.ex_rs2_s = 5;
      chk("fwd_ab_wb", ev(0, 0, 0, 0, 0, 2, 2));
      hz.ex_rs1_s = 0; hz.wb_rd_s = 0; hz.ex_rs2_s = 0;
      chk("fwd_x0", 10'd0);
`endif
      tick(); clr();

      // Data wait with a load-use hazard pending underneath.
      hz.dmem_req = 1;
      chk("dwait_req", 10'd0);
      tick(); hz.dmem_req = 0; id_add(); ex_lw_x5();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("dwait_frozen_%0d", i), ev(1, 0, 0, 0, 0, 0, 0));
         tick();
      end
      hz.dmem_resp = 1;
      chk("dwait_release_stall", ev(0, 1, 0, 0, 0, 0, 0));
      tick(); clr();
      chk("dwait_done", 10'd0);

      // Back-to-back fetch keeps the pending flag set.
      hz.imem_req = 1;
      tick(); hz.imem_resp = 1;
      chk("b2b_resp", 10'd0);
      tick(); clr();
      chk("b2b_still_pending", ev(1, 0, 0, 0, 0, 0, 0));
      hz.imem_resp = 1;
      tick(); clr();
      chk("b2b_done", 10'd0);

      // Taken branch with a wrong-path fetch outstanding.
      hz.imem_req = 1;
      tick(); hz.imem_req = 0; hz.br_taken = 1;
      chk("br_frozen", ev(1, 0, 0, 0, 0, 0, 0));
      tick(); hz.imem_resp = 1;
      chk("br_redirect_drop", ev(0, 0, 1, 1, 1, 0, 0));
      tick(); hz.imem_resp = 0; hz.br_taken = 0; id_add(); ex_lw_x5();
      chk("br_flush2_no_stall", ev(0, 0, 0, 1, 0, 0, 0));
      tick();
      chk("br_run_stall", ev(0, 1, 0, 0, 0, 0, 0));
      clr(); hz.imem_req = 1;
      tick(); hz.imem_req = 0; hz.imem_resp = 1;
      chk("br_next_resp_kept", 10'd0);
      tick(); clr();

      // Flush beats RAW stall; a branch inside FLUSH restarts the count.
      hz.br_taken = 1; id_add(); ex_lw_x5();
      chk("prio_flush", ev(0, 0, 1, 1, 0, 0, 0));
      tick();
      chk("restart_in_flush", ev(0, 0, 1, 1, 0, 0, 0));
      tick(); hz.br_taken = 0;
      chk("restart_tail", ev(0, 0, 0, 1, 0, 0, 0));
      tick(); clr();
      chk("restart_back_to_run", 10'd0);

      // Reset while frozen in a redirect with wrong_path set.
      hz.imem_req = 1;
      tick(); hz.imem_req = 0; hz.br_taken = 1;
      chk("rst_setup_frozen", ev(1, 0, 0, 0, 0, 0, 0));
      tick(); rst = 1; hz.imem_resp = 1;
      chk("rst_mid_op", 10'd0);
      tick(); rst = 0; clr(); hz.imem_resp = 1;
      chk("rst_no_drop", 10'd0);
      tick(); clr();
      chk("rst_idle", 10'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
